// File: rtl/mem_pkg.sv
// Shared definitions for the banked memory responder: bank geometry,
// word width, the read-pipeline stage record and the bank-select helper.
package mem_pkg;

    localparam int NUM_BANKS    = 4;
    localparam int BANK_SEL_LSB = 1;
    localparam int BANK_SEL_MSB = 2;
    localparam int WORD_W       = 16;

    // One slot of the read-return pipeline
    typedef struct packed {
        logic              vld;
        logic [WORD_W-1:0] data;
    } rd_stage_t;

    // Bank index from the low byte-address bits (bit 0 is the byte lane)
    function automatic logic [1:0] bank_of(input logic [2:0] addr_lo);
        return addr_lo[BANK_SEL_MSB:BANK_SEL_LSB];
    endfunction

endpackage

// File: rtl/banked_mem_responder_if.sv
// Request/response bus between the cache controller (master) and the
// banked memory responder (slave).
interface banked_mem_responder_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0]                  addr;
    logic [mem_pkg::WORD_W-1:0]         data_in;
    logic                               rd;
    logic                               wr;
    logic                               stall;
    logic                               done;
    logic [mem_pkg::WORD_W-1:0]         data_out;
    logic [mem_pkg::NUM_BANKS-1:0]      busy;
    logic                               err;

    modport master (
        output addr, data_in, rd, wr,
        input  stall, done, data_out, busy, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output stall, done, data_out, busy, err
    );
endinterface

// File: rtl/bank_busy_ctr.sv
// Per-bank occupancy counter: loaded on an accepted access, counts down
// to zero, and reports busy while nonzero.
module bank_busy_ctr #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);
    logic [CNT_W-1:0] cnt;

    // Load on access, otherwise count down until idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/banked_mem_responder.sv
// Main-memory responder for cache fills and write-backs. Four word-
// interleaved banks, each occupied for BANK_BUSY cycles after an access;
// reads return after READ_LAT cycles. Optional protocol-error checking
// is enabled by defining MEM_ERR_EN (rd&wr together, or an odd byte
// address, is then rejected and flagged on err).
module banked_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BANK_BUSY = 4,
    parameter int READ_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    banked_mem_responder_if.slave  bus
);
    localparam int              CNT_W    = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;
    localparam int              WORDS    = 2 ** (ADDR_W - 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BANK_BUSY - 1);

    logic [1:0]           bank;
    logic [ADDR_W-2:0]    word;
    logic                 req;
    logic                 bad;
    logic                 accept;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [NUM_BANKS-1:0] busy_vec;
    logic [NUM_BANKS-1:0] load_vec;

    logic [WORD_W-1:0]    mem_array [WORDS];
    rd_stage_t            rd_pipe_p [READ_LAT];

    assign bank = bank_of(bus.addr[2:0]);
    assign word = bus.addr[ADDR_W-1:1];
    assign req  = bus.rd | bus.wr;

`ifdef MEM_ERR_EN
    assign bad  = (bus.rd & bus.wr) | (req & bus.addr[0]);
`else
    logic unused_lsb;
    assign unused_lsb = bus.addr[0];
    assign bad        = 1'b0;
`endif

    // A rejected (bad) request neither stalls nor changes state; nothing is
    // accepted while reset is held so the array cannot be disturbed.
    assign bus.stall = req & ~bad & busy_vec[bank];
    assign accept    = rst & req & ~bad & ~busy_vec[bank];
    assign wr_acc    = accept & bus.wr;
    assign rd_acc    = accept & bus.rd & ~bus.wr;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign load_vec[b] = accept & (bank == 2'(b));

        bank_busy_ctr #(.CNT_W(CNT_W)) u_ctr (
            .clk      (clk),
            .rst      (rst),
            .load     (load_vec[b]),
            .load_val (LOAD_VAL),
            .busy     (busy_vec[b])
        );
    end

    assign bus.busy = busy_vec;

    // Backing array: written on an accepted write, retained across reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_array[word] <= bus.data_in;
        end
    end

    // Read return pipeline: stage 0 captures the word at acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                rd_pipe_p[i] <= '0;
            end
        end else begin
            rd_pipe_p[0] <= '{vld: rd_acc, data: mem_array[word]};
            for (int i = 1; i < READ_LAT; i++) begin
                rd_pipe_p[i] <= rd_pipe_p[i-1];
            end
        end
    end

    assign bus.done     = rd_pipe_p[READ_LAT-1].vld;
    assign bus.data_out = rd_pipe_p[READ_LAT-1].data;

`ifdef MEM_ERR_EN
    logic err_q;

    // One-cycle error pulse following a malformed request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bad;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_banked_mem_responder.sv
// Self-checking bench for banked_mem_responder: directed scenarios then a
// randomized request stream, all compared against a cycle-level model of
// bank occupancy, array contents and read-return timing.
module tb_banked_mem_responder;
    localparam int ADDR_W    = 16;
    localparam int BANK_BUSY = 4;
    localparam int READ_LAT  = 2;
`ifdef MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    banked_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    banked_mem_responder #(
        .ADDR_W    (ADDR_W),
        .BANK_BUSY (BANK_BUSY),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          edge_n   = 0;
    int          free_edge [4];
    logic [15:0] mem_m [int];
    logic [16:0] exp_done [int];
    bit          err_exp  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) free_edge[b] = 0;
        exp_done.delete();
        err_exp = 1'b0;
    endtask

    task automatic check_outputs();
        bit          de;
        logic [16:0] ent;
        logic [3:0]  bv;
        de = exp_done.exists(edge_n);
        chk("done", bus.done, de);
        if (de) begin
            ent = exp_done[edge_n];
            if (ent[16]) chk("data_out", bus.data_out, ent[15:0]);
            exp_done.delete(edge_n);
        end
        for (int b = 0; b < 4; b++) bv[b] = (edge_n + 1 < free_edge[b]);
        chk("busy", bus.busy, bv);
        chk("err", bus.err, err_exp);
    endtask

    // One clock: drive at negedge, check stall, advance model, check outputs
    task automatic cycle(input bit r, input bit w, input logic [15:0] a,
                         input logic [15:0] d, output bit stalled);
        int b;
        int wd;
        bit rq;
        bit bad;
        bit acc;
        bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = d;
        #1;
        b   = int'(a[2:1]);
        wd  = int'(a[15:1]);
        rq  = r | w;
        bad = ERR_EN && ((r && w) || (rq && a[0]));
        stalled = rq && !bad && (edge_n + 1 < free_edge[b]);
        chk("stall", bus.stall, stalled);
        acc = rq && !bad && !stalled;
        @(posedge clk);
        edge_n++;
        if (acc) begin
            free_edge[b] = edge_n + BANK_BUSY;
            if (w) mem_m[wd] = d;
            else exp_done[edge_n + READ_LAT - 1] =
                     mem_m.exists(wd) ? {1'b1, mem_m[wd]} : 17'h0;
        end
        err_exp = bad;
        @(negedge clk);
        check_outputs();
    endtask

    // Present a request and hold it while stalled; returns stall count
    task automatic request(input bit r, input bit w, input logic [15:0] a,
                           input logic [15:0] d, output int nst);
        bit st;
        nst = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(r, w, a, d, st);
            if (!st) return;
            nst++;
        end
        checks++;
        failures++;
        $error("FAIL req_timeout observed=stalled expected=accepted addr=%0h", a);
    endtask

    task automatic idle(input int n);
        bit st;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, st);
    endtask

    initial begin
        int n;
        int tot;
        int kind;
        logic [15:0] a;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_data_out", bus.data_out, 16'h0000);
        chk("rst_busy", bus.busy, 4'b0000);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_stall", bus.stall, 1'b0);
        rst = 1'b1;
        model_reset();

        // Preload and fill-style reads across four banks
        tot = 0;
        request(1'b0, 1'b1, 16'h0000, 16'h1111, n); tot += n;
        request(1'b0, 1'b1, 16'h0002, 16'h2222, n); tot += n;
        request(1'b0, 1'b1, 16'h0004, 16'h3333, n); tot += n;
        request(1'b0, 1'b1, 16'h0006, 16'h4444, n); tot += n;
        idle(4);
        for (int i = 0; i < 4; i++) begin
            request(1'b1, 1'b0, 16'(2 * i), 16'h0, n); tot += n;
        end
        chk("fill_stalls", tot, 0);
        idle(3);

        // Read-after-write to the same bank
        request(1'b0, 1'b1, 16'h0010, 16'hBEEF, n);
        request(1'b1, 1'b0, 16'h0010, 16'h0, n);
        chk("raw_stalls", n, BANK_BUSY - 1);
        idle(3);

        // Back-to-back reads in bank 0
        request(1'b0, 1'b1, 16'h0008, 16'h0808, n);
        request(1'b0, 1'b1, 16'h0018, 16'h1818, n);
        idle(4);
        request(1'b1, 1'b0, 16'h0008, 16'h0, n);
        request(1'b1, 1'b0, 16'h0018, 16'h0, n);
        chk("same_bank_stalls", n, BANK_BUSY - 1);
        idle(3);

        // Write-back style writes then reads
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            request(1'b0, 1'b1, 16'(2 * i), 16'(16'hA0 + i), n); tot += n;
        end
        for (int i = 0; i < 4; i++) begin
            request(1'b1, 1'b0, 16'(2 * i), 16'h0, n); tot += n;
        end
        chk("wb_stalls", tot, 0);
        idle(3);

        // Reset with a read in flight
        request(1'b1, 1'b0, 16'h0002, 16'h0, n);
        bus.rd = 1'b0; bus.wr = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 4'b0000);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_data_out", bus.data_out, 16'h0000);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b1;
        request(1'b1, 1'b0, 16'h0002, 16'h0, n);
        idle(3);

        // Malformed requests (rejected with MEM_ERR_EN, else write/read)
        request(1'b1, 1'b1, 16'h0002, 16'h5555, n);
        request(1'b1, 1'b0, 16'h0003, 16'h0, n);
        idle(4);

        // Randomized traffic over a small, fully initialised window
        for (int i = 0; i < 32; i++) request(1'b0, 1'b1, 16'(2 * i), 16'($urandom), n);
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            a    = 16'($urandom_range(0, 63));
            if (kind <= 3)      request(1'b1, 1'b0, a, 16'h0, n);
            else if (kind <= 7) request(1'b0, 1'b1, a, 16'($urandom), n);
            else if (kind == 8) request(1'b1, 1'b1, a, 16'($urandom), n);
            else                idle(1);
        end
        idle(READ_LAT + 2);
        chk("drain", exp_done.num(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/banked_mem_responder.md
# banked_mem_responder

Main-memory side of the cache fill/write-back protocol. Accepts single-word read and write requests, each with a word offset, from the cache controller. The memory is split into four interleaved banks, and each bank stays busy for a fixed number of cycles after every access. The block raises `stall` whenever the target bank is busy and returns read data a fixed number of cycles after the request is accepted. It sits between the cache controller and the backing store in the memory subsystem.

## Interface
Parameters:
- `ADDR_W`, 16, byte-address width; word storage depth is 2^(ADDR_W-1)
- `BANK_BUSY`, 4, cycles a bank is occupied after an accepted access (≥1)
- `READ_LAT`, 2, cycles from read acceptance to `done`/`data_out` (≥1)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `addr`  in  ADDR_W  byte address; bank = `addr[2:1]`, word = `addr[ADDR_W-1:1]`
- `data_in`  in  16  write data
- `rd`  in  1  read request
- `wr`  in  1  write request
- `stall`  out  1  request not accepted this cycle; requester holds `addr`/`data_in`/`rd`/`wr`
- `done`  out  1  one-cycle pulse, `data_out` valid
- `data_out`  out  16  read data
- `busy`  out  4  per-bank busy flags
- `err`  out  1  protocol error pulse (see Configuration)

## Operation
- A request is present when `rd|wr` is high. It is accepted on a rising edge when `busy[bank]==0`. An accepted request is not stalled.
- `stall` = (`rd|wr`) & `busy[bank]`. This is combinational and has no dependence on `done`.
- Accept actions:
  - Load that bank's counter with BANK_BUSY-1.
  - For `wr`: write `data_in` to the array on the same edge.
  - For `rd`: capture the array word into the read pipeline slot.
- A bank counter decrements each cycle while nonzero. `busy[b]` = counter≠0.
- With BANK_BUSY=1, a bank never reports busy, so back-to-back same-bank accesses are legal.
- Read pipeline: READ_LAT-stage shift of {valid, data}. The last stage drives `done` and `data_out`.
- Write acceptances produce no `done`.
- Accesses to four different banks on consecutive cycles are all accepted without stall. This covers the offset sequence 0,2,4,6 used by fills and write-backs.
- Read-after-write to the same bank stalls until that bank frees. The read then returns the new data.
- Read data is the array content at the acceptance edge. A later write does not alter the in-flight data.
- `rd&wr` together: see Configuration.
- Reset:
  - Clears all bank counters, the read pipeline, `done`, `data_out` (0x0000) and `err`.
  - Array contents are retained.
  - Asserting reset mid-operation discards in-flight reads. No `done` is produced for them.

## Timing
- Reset values: `done`=0, `data_out`=0x0000, `busy`=4'b0000, `err`=0. `stall` follows inputs, so it is 0 with an idle bus.
- Read accepted at edge N: `done`=1 and `data_out` valid in the cycle after edge N+READ_LAT-1 (default: 2 cycles after the request cycle).
- A bank accepted at edge N is busy for cycles N+1 … N+BANK_BUSY-1 and can accept again at edge N+BANK_BUSY.
- Throughput: one accepted request per cycle across distinct banks. `done` pulses may occur on consecutive cycles.

## Configuration
- `MEM_ERR_EN` defined:
  - `err` pulses for one cycle, registered, after any cycle with `rd&wr`, or with `rd|wr` and `addr[0]`=1.
  - The offending request is not accepted, `stall`=0 for it, and no state changes.
- `MEM_ERR_EN` undefined:
  - `err` is tied 0.
  - `rd&wr` is treated as a write.
  - `addr[0]` is ignored.

## Structure
- Shared package `mem_pkg`:
  - `NUM_BANKS`=4
  - `BANK_SEL_LSB`=1, `BANK_SEL_MSB`=2
  - `WORD_W`=16
  - typedef for the read-pipeline stage {valid, data}
- Sub-module `bank_busy_ctr`:
  - One instance per bank.
  - Inputs: `load` and the BANK_BUSY-1 load value.
  - Decrements to zero and outputs `busy`.
- The array and read pipeline stay in the top module.

## Test plan
- Reset, then read 0x0000, 0x0002, 0x0004, 0x0006 on four consecutive cycles after preloading 0x1111/0x2222/0x3333/0x4444 → `stall` is never 1; `done` pulses on four consecutive cycles starting 2 cycles after the first request, with data in order.
- Write 0xBEEF @0x0010, then immediately read @0x0010 → read stalls 3 cycles; after acceptance, `done` with 0xBEEF 2 cycles later.
- Back-to-back reads @0x0008 and @0x0018 (same bank 0) → second request `stall`=1 for 3 cycles; `busy[0]`=1 during that window.
- Four writes to offsets 0,2,4,6 (0xA0..0xA3), then reads of the same words → no stalls on writes, no `done` on writes; reads return 0xA0..0xA3.
- Accept a read, then drop `rst` low the next cycle → `done` never pulses; `busy`=0 immediately; the array word is unchanged on re-read.
- With `MEM_ERR_EN`: `rd`=`wr`=1 @0x0002, then read @0x0003 → `err` pulses once after each; `busy` stays 0; no `done`.
